fp_minmax_scan: RTL and testbench

//  Streaming initiator of single-precision compares. Accepts a framed stream of

---
 rtl/fp_minmax_scan.sv | 197 +++++++++++++++++++
 tb/tb_fp_minmax_scan.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_minmax_scan.sv
`default_nettype none
// ============================================================================
//  Module      : fp_minmax_scan
//  Description : Framed binary32 stream scanner. Tracks the running minimum
//                and maximum, and the index of each, under a sign-magnitude
//                ordering. Emits one result record per frame on valid/ready.
//  Option      : define FP_NAN_CHECK_EN to exclude NaN words from min/max
//                and report them on out_nan_seen.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_minmax_scan #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_min,
    output logic [31:0]      out_max,
    output logic [IDX_W-1:0] out_min_idx,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [IDX_W-1:0] out_count,
    output logic             out_nan_seen
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_CNT_MAX = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] c_ONE     = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      c_QNAN    = 32'h7FC0_0000;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_word;
    logic             r_last;
    logic             r_have;
    logic [31:0]      r_min;
    logic [31:0]      r_max;
    logic [IDX_W-1:0] r_min_idx;
    logic [IDX_W-1:0] r_max_idx;
    logic [IDX_W-1:0] r_count;
    logic             r_nan_seen;
    logic             w_is_nan;
    logic             w_lt_min;
    logic             w_gt_max;

    // a < b under sign-magnitude order; +0 and -0 compare equal
    function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
        logic r;
        r = 1'b0;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
            r = 1'b0;
        end else if (a == b) begin
            r = 1'b0;
        end else if (a[31] != b[31]) begin
            r = a[31];
        end else if (!a[31]) begin
            r = (a[30:0] < b[30:0]);
        end else begin
            r = (a[30:0] > b[30:0]);
        end
        return r;
    endfunction

`ifdef FP_NAN_CHECK_EN
    assign w_is_nan = (&r_word[30:23]) && (|r_word[22:0]);
`else
    assign w_is_nan = 1'b0;
`endif

    assign w_lt_min = f_lt(r_word, r_min);
    assign w_gt_max = f_lt(r_max, r_word);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_CMP;
                end
            end
            S_CMP: begin
                w_next = r_last ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, compare/update, and frame clear on result acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word     <= '0;
            r_last     <= 1'b0;
            r_have     <= 1'b0;
            r_min      <= '0;
            r_max      <= '0;
            r_min_idx  <= '0;
            r_max_idx  <= '0;
            r_count    <= '0;
            r_nan_seen <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_word <= in_data;
                        r_last <= in_last;
                    end
                end
                S_CMP: begin
                    // Index of this word is the count before increment
                    if (r_count != c_CNT_MAX) begin
                        r_count <= r_count + c_ONE;
                    end
                    if (w_is_nan) begin
                        r_nan_seen <= 1'b1;
                        // Canonical quiet NaN until a non-NaN word arrives
                        if (!r_have) begin
                            r_min     <= c_QNAN;
                            r_max     <= c_QNAN;
                            r_min_idx <= '0;
                            r_max_idx <= '0;
                        end
                    end else if (!r_have) begin
                        r_have    <= 1'b1;
                        r_min     <= r_word;
                        r_max     <= r_word;
                        r_min_idx <= r_count;
                        r_max_idx <= r_count;
                    end else begin
                        if (w_lt_min) begin
                            r_min     <= r_word;
                            r_min_idx <= r_count;
                        end
                        if (w_gt_max) begin
                            r_max     <= r_word;
                            r_max_idx <= r_count;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_word     <= '0;
                        r_last     <= 1'b0;
                        r_have     <= 1'b0;
                        r_min      <= '0;
                        r_max      <= '0;
                        r_min_idx  <= '0;
                        r_max_idx  <= '0;
                        r_count    <= '0;
                        r_nan_seen <= 1'b0;
                    end
                end
                default: begin
                    r_last <= 1'b0;
                end
            endcase
        end
    end

    assign out_min      = r_min;
    assign out_max      = r_max;
    assign out_min_idx  = r_min_idx;
    assign out_max_idx  = r_max_idx;
    assign out_count    = r_count;
    assign out_nan_seen = r_nan_seen;

endmodule
`default_nettype wire

// File: tb/tb_fp_minmax_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_minmax_scan
//  Description : Self-checking bench for fp_minmax_scan. Two instances
//                (IDX_W=8 and IDX_W=2) share the input stream; results are
//                compared against fixed vectors and a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_minmax_scan;

    typedef struct {
        logic [31:0] mn;
        logic [31:0] mx;
        int          mni;
        int          mxi;
        int          cnt;
        int          nan;
    } res_t;

    typedef struct packed {
        logic [5:0][31:0] w;
        logic [2:0]       n;
        logic [31:0]      mn;
        logic [31:0]      mx;
        logic [7:0]       mni;
        logic [7:0]       mxi;
        logic [7:0]       cnt;
        logic             nan;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_nan;
    logic [31:0] a_min, a_max;
    logic [7:0]  a_min_idx, a_max_idx, a_count;
    logic        b_in_ready, b_out_valid, b_nan;
    logic [31:0] b_min, b_max;
    logic [1:0]  b_min_idx, b_max_idx, b_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_minmax_scan #(.IDX_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_min(a_min), .out_max(a_max),
        .out_min_idx(a_min_idx), .out_max_idx(a_max_idx),
        .out_count(a_count), .out_nan_seen(a_nan)
    );

    fp_minmax_scan #(.IDX_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_min(b_min), .out_max(b_max),
        .out_min_idx(b_min_idx), .out_max_idx(b_max_idx),
        .out_count(b_count), .out_nan_seen(b_nan)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Real-number position on a line: negatives below zero, -0 == +0
    function automatic longint key(input logic [31:0] a);
        longint m;
        m = longint'(a[30:0]);
        return a[31] ? -m : m;
    endfunction

    function automatic bit is_nan(input logic [31:0] a);
`ifdef FP_NAN_CHECK_EN
        return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic res_t model(input logic [31:0] q[$], input int maxc);
        res_t r;
        bit   have;
        int   idx;
        r = '{mn: 32'd0, mx: 32'd0, mni: 0, mxi: 0, cnt: 0, nan: 0};
        have = 0;
        for (int i = 0; i < q.size(); i++) begin
            idx   = (i > maxc) ? maxc : i;
            r.cnt = (i + 1 > maxc) ? maxc : i + 1;
            if (is_nan(q[i])) begin
                r.nan = 1;
                if (!have) begin
                    r.mn = 32'h7FC00000; r.mx = 32'h7FC00000; r.mni = 0; r.mxi = 0;
                end
            end else if (!have) begin
                have = 1;
                r.mn = q[i]; r.mx = q[i]; r.mni = idx; r.mxi = idx;
            end else begin
                if (key(q[i]) < key(r.mn)) begin r.mn = q[i]; r.mni = idx; end
                if (key(q[i]) > key(r.mx)) begin r.mx = q[i]; r.mxi = idx; end
            end
        end
        return r;
    endfunction

    task automatic cmp(input string tag, input res_t g, input res_t e);
        chk({tag, " min"},     longint'(g.mn),  longint'(e.mn));
        chk({tag, " max"},     longint'(g.mx),  longint'(e.mx));
        chk({tag, " min_idx"}, longint'(g.mni), longint'(e.mni));
        chk({tag, " max_idx"}, longint'(g.mxi), longint'(e.mxi));
        chk({tag, " count"},   longint'(g.cnt), longint'(e.cnt));
        chk({tag, " nan"},     longint'(g.nan), longint'(e.nan));
    endtask

    // Stream one frame, wait for both records, hold for 'hold' cycles, accept
    task automatic run_frame(input string tag, input logic [31:0] q[$], input int hold,
                             output res_t ra, output res_t rb);
        int t;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            t = 0;
            while (!a_in_ready && t < 10) begin @(negedge clk); t++; end
            chk({tag, " in_ready timeout"}, longint'(a_in_ready & b_in_ready), 1);
            in_valid = 1'b1;
            in_data  = q[i];
            in_last  = (i == q.size() - 1);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        // One cycle after the last accept the block is still comparing
        chk({tag, " early out_valid"}, longint'(a_out_valid), 0);
        t = 0;
        while (!a_out_valid && t < 4) begin @(negedge clk); t++; end
        chk({tag, " out_valid"}, longint'(a_out_valid), 1);
        chk({tag, " b out_valid"}, longint'(b_out_valid), 1);
        ra = '{mn: a_min, mx: a_max, mni: int'(a_min_idx), mxi: int'(a_max_idx),
               cnt: int'(a_count), nan: int'(a_nan)};
        rb = '{mn: b_min, mx: b_max, mni: int'(b_min_idx), mxi: int'(b_max_idx),
               cnt: int'(b_count), nan: int'(b_nan)};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, " hold valid"},   longint'(a_out_valid), 1);
            chk({tag, " hold in_ready"}, longint'(a_in_ready), 0);
            chk({tag, " hold min"},     longint'(a_min), longint'(ra.mn));
            chk({tag, " hold max"},     longint'(a_max), longint'(ra.mx));
            chk({tag, " hold count"},   longint'(a_count), longint'(ra.cnt));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid drop"}, longint'(a_out_valid), 0);
        chk({tag, " ready back"}, longint'(a_in_ready), 1);
    endtask

    function automatic res_t vec_res(input vec_t v);
        res_t r;
        r = '{mn: v.mn, mx: v.mx, mni: int'(v.mni), mxi: int'(v.mxi),
              cnt: int'(v.cnt), nan: int'(v.nan)};
        return r;
    endfunction

    initial begin
        vec_t        tbl[5];
        logic [31:0] q[$];
        res_t        ra, rb;
        logic [31:0] w;

        // T1..T5 expected results for the IDX_W=8 instance
        for (int i = 0; i < 5; i++) tbl[i] = '0;
        tbl[0].n = 4;
        tbl[0].w[0] = 32'h40400000; tbl[0].w[1] = 32'hBFC00000;
        tbl[0].w[2] = 32'h40E80000; tbl[0].w[3] = 32'h3F000000;
        tbl[0].mn = 32'hBFC00000; tbl[0].mni = 1;
        tbl[0].mx = 32'h40E80000; tbl[0].mxi = 2; tbl[0].cnt = 4;
        tbl[1].n = 2;
        tbl[1].w[0] = 32'h00000000; tbl[1].w[1] = 32'h80000000;
        tbl[1].mn = 32'h00000000; tbl[1].mx = 32'h00000000; tbl[1].cnt = 2;
        tbl[2].n = 3;
        tbl[2].w[0] = 32'hFF800000; tbl[2].w[1] = 32'h7F800000; tbl[2].w[2] = 32'h40000000;
        tbl[2].mn = 32'hFF800000; tbl[2].mni = 0;
        tbl[2].mx = 32'h7F800000; tbl[2].mxi = 1; tbl[2].cnt = 3;
        tbl[3].n = 6;
        tbl[3].w[0] = 32'h3F800000; tbl[3].w[1] = 32'h40000000; tbl[3].w[2] = 32'h40400000;
        tbl[3].w[3] = 32'h40800000; tbl[3].w[4] = 32'h40A00000; tbl[3].w[5] = 32'h40C00000;
        tbl[3].mn = 32'h3F800000; tbl[3].mni = 0;
        tbl[3].mx = 32'h40C00000; tbl[3].mxi = 5; tbl[3].cnt = 6;
        tbl[4].n = 3;
        tbl[4].w[0] = 32'h7FC00001; tbl[4].w[1] = 32'h3F800000; tbl[4].w[2] = 32'h7F800001;
        tbl[4].cnt = 3;
`ifdef FP_NAN_CHECK_EN
        tbl[4].mn = 32'h3F800000; tbl[4].mni = 1;
        tbl[4].mx = 32'h3F800000; tbl[4].mxi = 1; tbl[4].nan = 1;
`else
        tbl[4].mn = 32'h3F800000; tbl[4].mni = 1;
        tbl[4].mx = 32'h7FC00001; tbl[4].mxi = 0; tbl[4].nan = 0;
`endif

        // Reset state
        #2;
        chk("reset in_ready", longint'(a_in_ready), 1);
        chk("reset out_valid", longint'(a_out_valid), 0);
        chk("reset count", longint'(a_count), 0);
        chk("reset min", longint'(a_min), 0);
        chk("reset max_idx", longint'(a_max_idx), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int k = 0; k < 5; k++) begin
            q.delete();
            for (int i = 0; i < int'(tbl[k].n); i++) q.push_back(tbl[k].w[i]);
            run_frame($sformatf("T%0d", k + 1), q, (k == 2) ? 5 : 1, ra, rb);
            cmp($sformatf("T%0d a", k + 1), ra, vec_res(tbl[k]));
            cmp($sformatf("T%0d b", k + 1), rb, model(q, 3));
            if (k == 3) begin
                chk("T4 b count sat", longint'(rb.cnt), 3);
                chk("T4 b max", longint'(rb.mx), longint'(32'h40C00000));
                chk("T4 b max_idx", longint'(rb.mxi), 3);
            end
        end

        // T6: reset while a word is being compared
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hC1200000; in_last = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("T6 in_ready", longint'(a_in_ready), 1);
        chk("T6 out_valid", longint'(a_out_valid), 0);
        chk("T6 count", longint'(a_count), 0);
        chk("T6 min", longint'(a_min), 0);
        rst = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) q.push_back(tbl[0].w[i]);
        run_frame("T6 post", q, 0, ra, rb);
        cmp("T6 post a", ra, vec_res(tbl[0]));

        // Randomised frames against the reference model
        for (int f = 0; f < 40; f++) begin
            int len;
            q.delete();
            len = (f == 39) ? 260 : int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 7))
                    0: w = 32'h00000000;
                    1: w = 32'h80000000;
                    2: w = $urandom_range(0, 1) ? 32'h7F800000 : 32'hFF800000;
                    3: w = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
                    4: w = {$urandom_range(0, 1) == 1, 8'h00, 23'($urandom())};
                    default: w = $urandom();
                endcase
                q.push_back(w);
            end
            run_frame($sformatf("R%0d", f), q, int'($urandom_range(0, 2)), ra, rb);
            cmp($sformatf("R%0d a", f), ra, model(q, 255));
            cmp($sformatf("R%0d b", f), rb, model(q, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
